counter_sequencer: RTL and testbench
====================================

COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 SHALL have parameters: D_NUM, default 6, decade count of the driven counter; D_WIDTH, default 4, bits per decade; WIDTH, default D_NUM*D_WIDTH, counter value width; STEP_WIDTH, default 8, step-count width; ACK_TIMEOUT, default 4, cycles to wait for counter to go busy.
REQ-002 SHALL have ports (name  direction  width  meaning):
- Clk  in  1  single clock, rising edge
- Rst_n  in  1  asynchronous active-low reset
- Start  in  1  command strobe, sampled in IDLE only
- Dec  in  1  direction: 1 = decrement, 0 = increment
- Load  in  1  perform Set with LoadValue before stepping
- LoadValue  in  WIDTH  value for Set
- Steps  in  STEP_WIDTH  number of single-step operations
- StopOnZero  in  1  terminate early when CntZero after a step
- Abort  in  1  stop after in-flight operation
- Busy  out  1  command in progress
- Done  out  1  one-cycle completion pulse
- Remaining  out  STEP_WIDTH  steps not yet executed
- StoppedZero  out  1  last command ended on zero
- Aborted  out  1  last command ended by Abort
- CntRequest  out  1  one-cycle request to downstream counter
- CntDec  out  1  direction to counter
- CntSet  out  1  set strobe qualifier to counter
- CntIn  out  WIDTH  set value to counter
- CntReady  in  1  counter idle level
- CntZero  in  1  counter value is all zero

Function
REQ-003 SHALL implement states IDLE, ISSUE, WAIT_ACK, WAIT_RDY, FINISH.
REQ-004 In IDLE with Start=1, SHALL latch Dec, Load, LoadValue, Steps, StopOnZero, assert Busy next cycle, clear StoppedZero/Aborted, go to ISSUE.
REQ-005 Start while Busy SHALL be ignored.
REQ-006 ISSUE SHALL wait for CntReady=1, then pulse CntRequest one cycle; CntSet=1 for the latched-Load operation, else 0; CntDec=latched Dec held stable through WAIT_RDY; CntIn=latched LoadValue.
REQ-007 Load=1 SHALL issue exactly one Set operation before any step; Set does not decrement Remaining.
REQ-008 WAIT_ACK SHALL wait for CntReady=0; if not seen within ACK_TIMEOUT cycles, SHALL treat the operation as completed and go to completion check.
REQ-009 WAIT_RDY SHALL wait for CntReady=1, then complete the operation: step operations decrement Remaining by 1.
REQ-010 Completion check order: Abort latched -> FINISH, Aborted=1; else StopOnZero and CntZero (after a step, not after Set) -> FINISH, StoppedZero=1; else Remaining=0 -> FINISH; else ISSUE.
REQ-011 Abort SHALL be latched whenever Busy; never cut an in-flight request; Abort in IDLE ignored.
REQ-012 Steps=0 with Load=0 SHALL issue no CntRequest and reach FINISH in 2 cycles after Start.
REQ-013 FINISH SHALL pulse Done one cycle, deassert Busy same cycle as Done, return to IDLE; Remaining, StoppedZero, Aborted hold until next Start.
REQ-014 Wrap-around of the counter value is the counter's responsibility; sequencer never inspects CntIn/value except CntZero.
REQ-015 At most one CntRequest SHALL be outstanding; minimum spacing between CntRequest pulses is 3 cycles.

Reset
REQ-016 Rst_n=0 SHALL asynchronously force IDLE, Busy=0, Done=0, CntRequest=0, CntSet=0, CntDec=0, CntIn=0, Remaining=0, StoppedZero=0, Aborted=0, latched Abort=0.
REQ-017 Reset mid-operation SHALL abandon the command without completion pulse; first Start after release behaves as REQ-004.

Structure
REQ-018 State enum and default parameter constants SHALL reside in the shared Dekatron package.
REQ-019 Design SHALL be one module, no sub-modules; ACK_TIMEOUT counter inline.

Verification
REQ-020 Bench SHALL connect a Counter model with COUNT_DELAY=3 and cover:
- Start, Load=0, Dec=0, Steps=5, counter at 000007 -> five CntRequest pulses, counter 000012, Remaining=0, Done once, StoppedZero=0.
- Start, Load=1, LoadValue=000003, Dec=1, Steps=10, StopOnZero=1 -> one Set then 3 steps, counter 000000, Remaining=7, StoppedZero=1.
- Start, Dec=1, Steps=2 at 000000 -> counter 999998, Done, no StoppedZero with StopOnZero=0.
- Steps=4, Abort pulsed during second request -> exactly 2 steps complete, Remaining=2, Aborted=1.
- Steps=0, Load=0 -> no CntRequest, Done 2 cycles after Start; Start while Busy ignored.
- Rst_n low during WAIT_RDY -> all outputs reset values, no Done; counter model stalled with CntReady held 1 -> ACK_TIMEOUT path completes command.

Source files
------------

// File: rtl/counter_sequencer_pkg.sv
// Shared Dekatron definitions: sequencer state encoding, default sizes and
// a small sizing helper for the acknowledge-timeout counter.
package counter_sequencer_pkg;

    localparam int DEF_D_NUM       = 6;
    localparam int DEF_D_WIDTH     = 4;
    localparam int DEF_STEP_WIDTH  = 8;
    localparam int DEF_ACK_TIMEOUT = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        WAIT_ACK = 3'd2,
        WAIT_RDY = 3'd3,
        FINISH   = 3'd4
    } seq_state_t;

    // Width of a counter that must hold 0 .. timeout-1 (never narrower than 1 bit).
    function automatic int ack_cnt_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/counter_sequencer.sv
// Counter sequencer: runs an optional Set followed by a number of single
// steps on a downstream decade counter, with early stop on zero and abort.
//
// Counter handshake (CntRequest / CntReady):
//   A request is a one-cycle CntRequest pulse, only issued while the counter
//   reports CntReady=1. CntSet, CntDec and CntIn qualify the request and stay
//   stable until the operation completes. The counter acknowledges by dropping
//   CntReady and reports completion by raising it again. If the acknowledge
//   never arrives within ACK_TIMEOUT cycles the operation is taken as done.
//   Only one request is ever outstanding.
module counter_sequencer
    import counter_sequencer_pkg::*;
#(
    parameter int D_NUM       = DEF_D_NUM,
    parameter int D_WIDTH     = DEF_D_WIDTH,
    parameter int WIDTH       = D_NUM * D_WIDTH,
    parameter int STEP_WIDTH  = DEF_STEP_WIDTH,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  Start,
    input  logic                  Dec,
    input  logic                  Load,
    input  logic [WIDTH-1:0]      LoadValue,
    input  logic [STEP_WIDTH-1:0] Steps,
    input  logic                  StopOnZero,
    input  logic                  Abort,
    output logic                  Busy,
    output logic                  Done,
    output logic [STEP_WIDTH-1:0] Remaining,
    output logic                  StoppedZero,
    output logic                  Aborted,
    output logic                  CntRequest,
    output logic                  CntDec,
    output logic                  CntSet,
    output logic [WIDTH-1:0]      CntIn,
    input  logic                  CntReady,
    input  logic                  CntZero,
    output seq_state_t            DbgState
);

    localparam int              ACK_W    = ack_cnt_width(ACK_TIMEOUT);
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

    seq_state_t            state;
    logic                  load_pend;   // Set operation still owed before stepping
    logic                  soz_q;       // latched StopOnZero
    logic                  abort_q;     // Abort seen while busy
    logic [ACK_W-1:0]      ack_cnt;     // cycles spent waiting for the acknowledge

    logic                  step_op;
    logic                  abort_hit;
    logic                  op_done;
    logic [STEP_WIDTH-1:0] rem_after;

    // The in-flight operation is a step unless the Set is still pending.
    assign step_op   = !load_pend;
    assign rem_after = step_op ? (Remaining - STEP_WIDTH'(1)) : Remaining;
    assign abort_hit = abort_q | Abort;
    // Operation completes on counter ready in WAIT_RDY, or on acknowledge timeout.
    assign op_done   = CntReady && ((state == WAIT_RDY) ||
                                    ((state == WAIT_ACK) && (ack_cnt == ACK_LAST)));

    assign DbgState  = state;

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= IDLE;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            Remaining   <= '0;
            StoppedZero <= 1'b0;
            Aborted     <= 1'b0;
            CntRequest  <= 1'b0;
            CntDec      <= 1'b0;
            CntSet      <= 1'b0;
            CntIn       <= '0;
            load_pend   <= 1'b0;
            soz_q       <= 1'b0;
            abort_q     <= 1'b0;
            ack_cnt     <= '0;
        end else begin
            Done       <= 1'b0;
            CntRequest <= 1'b0;
            if (Busy && Abort) begin
                abort_q <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (Start) begin
                        Busy        <= 1'b1;
                        Remaining   <= Steps;
                        CntDec      <= Dec;
                        CntIn       <= LoadValue;
                        CntSet      <= 1'b0;
                        load_pend   <= Load;
                        soz_q       <= StopOnZero;
                        StoppedZero <= 1'b0;
                        Aborted     <= 1'b0;
                        abort_q     <= 1'b0;
                        state       <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (abort_q) begin
                        // Nothing in flight, so an abort can end the command here.
                        Aborted <= 1'b1;
                        Done    <= 1'b1;
                        Busy    <= 1'b0;
                        state   <= FINISH;
                    end else if (!load_pend && (Remaining == '0)) begin
                        Done  <= 1'b1;
                        Busy  <= 1'b0;
                        state <= FINISH;
                    end else if (CntReady) begin
                        CntRequest <= 1'b1;
                        CntSet     <= load_pend;
                        ack_cnt    <= '0;
                        state      <= WAIT_ACK;
                    end
                end

                WAIT_ACK: begin
                    if (!CntReady) begin
                        state <= WAIT_RDY;
                    end else begin
                        ack_cnt <= ack_cnt + ACK_W'(1);
                    end
                end

                WAIT_RDY: begin
                    // Completion is handled by the op_done block below.
                    state <= WAIT_RDY;
                end

                FINISH: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase

            // Operation completion: account the step, then decide where to go.
            if (op_done) begin
                CntSet    <= 1'b0;
                load_pend <= 1'b0;
                Remaining <= rem_after;
                if (abort_hit) begin
                    Aborted <= 1'b1;
                    Done    <= 1'b1;
                    Busy    <= 1'b0;
                    state   <= FINISH;
                end else if (soz_q && step_op && CntZero) begin
                    StoppedZero <= 1'b1;
                    Done        <= 1'b1;
                    Busy        <= 1'b0;
                    state       <= FINISH;
                end else if (rem_after == '0) begin
                    Done  <= 1'b1;
                    Busy  <= 1'b0;
                    state <= FINISH;
                end else begin
                    state <= ISSUE;
                end
            end
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: a behavioural decade counter (COUNT_DELAY=3),
// a request scoreboard fed by a command-level model, and directed plus
// randomized commands.
module tb_counter_sequencer;
    import counter_sequencer_pkg::*;

    localparam int D_NUM       = 6;
    localparam int D_WIDTH     = 4;
    localparam int WIDTH       = D_NUM * D_WIDTH;
    localparam int STEP_WIDTH  = 8;
    localparam int ACK_TIMEOUT = 4;
    localparam int COUNT_DELAY = 3;
    localparam int MODULUS     = 1000000;

    // ---------------- clock / reset ----------------
    logic Clk   = 1'b0;
    logic Rst_n = 1'b0;
    always #5 Clk = ~Clk;

    logic                  Start = 1'b0, Dec = 1'b0, Load = 1'b0, StopOnZero = 1'b0, Abort = 1'b0;
    logic [WIDTH-1:0]      LoadValue = '0;
    logic [STEP_WIDTH-1:0] Steps = '0;
    logic                  Busy, Done, StoppedZero, Aborted, CntRequest, CntDec, CntSet;
    logic [STEP_WIDTH-1:0] Remaining;
    logic [WIDTH-1:0]      CntIn;
    logic                  CntReady, CntZero;
    seq_state_t            DbgState;

    counter_sequencer #(
        .D_NUM(D_NUM), .D_WIDTH(D_WIDTH), .WIDTH(WIDTH),
        .STEP_WIDTH(STEP_WIDTH), .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Dec(Dec), .Load(Load),
        .LoadValue(LoadValue), .Steps(Steps), .StopOnZero(StopOnZero), .Abort(Abort),
        .Busy(Busy), .Done(Done), .Remaining(Remaining), .StoppedZero(StoppedZero),
        .Aborted(Aborted), .CntRequest(CntRequest), .CntDec(CntDec), .CntSet(CntSet),
        .CntIn(CntIn), .CntReady(CntReady), .CntZero(CntZero), .DbgState(DbgState)
    );

    // ---------------- bookkeeping ----------------
    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int gap = 1000;
    bit cur_dec = 1'b0;
    logic [WIDTH+1:0] exp_q[$];   // expected {CntSet, CntDec, CntIn} per request

    task automatic chk(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    function automatic logic [WIDTH-1:0] int2bcd(input int v);
        logic [WIDTH-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < D_NUM; i++) begin
            r[i*D_WIDTH +: D_WIDTH] = D_WIDTH'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int bcd2int(input logic [WIDTH-1:0] b);
        int v;
        v = 0;
        for (int i = D_NUM - 1; i >= 0; i--) begin
            v = v * 10 + int'(b[i*D_WIDTH +: D_WIDTH]);
        end
        return v;
    endfunction

    // ---------------- behavioural counter ----------------
    int   cnt_val = 0;
    logic cnt_ready = 1'b1;
    int   dly = 0;
    logic op_set = 1'b0, op_dec = 1'b0;
    int   op_in = 0;
    bit   stall = 1'b0;
    bit   pre_en = 1'b0;
    int   pre_val = 0;

    always @(posedge Clk) begin
        if (pre_en) begin
            cnt_val <= pre_val;
        end else if (!cnt_ready) begin
            if (dly >= COUNT_DELAY - 1) begin
                cnt_ready <= 1'b1;
                if (op_set) cnt_val <= op_in;
                else if (op_dec) cnt_val <= (cnt_val + MODULUS - 1) % MODULUS;
                else cnt_val <= (cnt_val + 1) % MODULUS;
            end else begin
                dly <= dly + 1;
            end
        end else if (CntRequest && !stall) begin
            cnt_ready <= 1'b0;
            dly       <= 0;
            op_set    <= CntSet;
            op_dec    <= CntDec;
            op_in     <= bcd2int(CntIn);
        end
    end
    assign CntReady = cnt_ready;
    assign CntZero  = (cnt_val == 0);

    // ---------------- command-level model ----------------
    // Produces the request stream and the final outcome of one command.
    task automatic model_cmd(input int v0, input bit dec, input bit load, input int lv,
                             input int steps, input bit soz, input bit stalled,
                             output int v, output int rem, output bit sz);
        v   = v0;
        rem = steps;
        sz  = 1'b0;
        if (load) begin
            exp_q.push_back({1'b1, dec, int2bcd(lv)});
            if (!stalled) v = lv;
        end
        while (rem > 0) begin
            exp_q.push_back({1'b0, dec, int2bcd(lv)});
            if (!stalled) v = dec ? (v + MODULUS - 1) % MODULUS : (v + 1) % MODULUS;
            rem--;
            if (soz && v == 0) begin
                sz = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge Clk) begin
        if (Rst_n) begin
            if (Done) begin
                done_cnt++;
                chk("busy_low_with_done", Busy, 0);
            end
            if (CntRequest) begin
                chk("req_while_busy", Busy, 1);
                chk("req_spacing_ge3", (gap >= 2), 1);
                chk("req_expected", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    chk("req_set_dec_in", {CntSet, CntDec, CntIn}, exp_q.pop_front());
                end
                gap = 0;
            end else if (gap < 1000) begin
                gap++;
            end
            if (Busy && !cnt_ready) chk("cnt_dec_held", CntDec, cur_dec);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic preload(input int v);
        @(posedge Clk); #1;
        pre_val = v;
        pre_en  = 1'b1;
        @(posedge Clk); #1;
        pre_en  = 1'b0;
    endtask

    task automatic issue_start(input bit dec, input bit load, input int lv,
                               input int steps, input bit soz);
        @(posedge Clk); #1;
        Dec        = dec;
        Load       = load;
        LoadValue  = int2bcd(lv);
        Steps      = STEP_WIDTH'(steps);
        StopOnZero = soz;
        cur_dec    = dec;
        done_cnt   = 0;
        Start      = 1'b1;
        @(posedge Clk); #1;
        Start      = 1'b0;
        chk("busy_after_start", Busy, 1);
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge Clk);
            if (Done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", seen, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, Busy, 0);
        chk({tag, "_done"}, Done, 0);
        chk({tag, "_req"}, CntRequest, 0);
        chk({tag, "_set"}, CntSet, 0);
        chk({tag, "_dec"}, CntDec, 0);
        chk({tag, "_cntin"}, CntIn, 0);
        chk({tag, "_remaining"}, Remaining, 0);
        chk({tag, "_stoppedzero"}, StoppedZero, 0);
        chk({tag, "_aborted"}, Aborted, 0);
        chk({tag, "_state_idle"}, (DbgState == IDLE), 1);
    endtask

    // Full command with model-derived expectations; glitch pulses Start mid-command.
    task automatic run_cmd(input bit dec, input bit load, input int lv, input int steps,
                           input bit soz, input bit stalled, input bit glitch);
        int ev, er;
        bit es, seen;
        model_cmd(cnt_val, dec, load, lv, steps, soz, stalled, ev, er, es);
        issue_start(dec, load, lv, steps, soz);
        if (glitch) begin
            repeat (2) @(posedge Clk);
            #1;
            Dec       = !dec;
            Load      = !load;
            Steps     = STEP_WIDTH'(steps + 3);
            LoadValue = int2bcd(777);
            Start     = 1'b1;
            @(posedge Clk); #1;
            Start     = 1'b0;
        end
        wait_done(seen);
        chk("remaining", Remaining, er);
        chk("stopped_zero", StoppedZero, es);
        chk("aborted", Aborted, 0);
        chk("counter_value", cnt_val, ev);
        chk("requests_left", exp_q.size(), 0);
        repeat (3) @(negedge Clk);
        chk("done_once", done_cnt, 1);
        chk("remaining_hold", Remaining, er);
        chk("busy_idle", Busy, 0);
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int ev, er, nreq, pick, v0;
        bit es, seen, hit;

        #3;
        check_reset_outputs("reset");
        repeat (2) @(posedge Clk);
        #1 Rst_n = 1'b1;

        // Five increments from 7.
        preload(7);
        run_cmd(1'b0, 1'b0, 0, 5, 1'b0, 1'b0, 1'b0);
        chk("s1_counter_12", cnt_val, 12);

        // Set 3 then count down, stopping on zero.
        run_cmd(1'b1, 1'b1, 3, 10, 1'b1, 1'b0, 1'b0);
        chk("s2_counter_0", cnt_val, 0);
        chk("s2_remaining_7", Remaining, 7);
        chk("s2_stopped_zero", StoppedZero, 1);

        // Decrement through zero without stop-on-zero.
        run_cmd(1'b1, 1'b0, 0, 2, 1'b0, 1'b0, 1'b0);
        chk("s3_counter_999998", cnt_val, 999998);
        chk("s3_no_stopped_zero", StoppedZero, 0);

        // Abort during the second request.
        preload(100);
        model_cmd(cnt_val, 1'b0, 1'b0, 5, 4, 1'b0, 1'b0, ev, er, es);
        issue_start(1'b0, 1'b0, 5, 4, 1'b0);
        nreq = 0;
        for (int c = 0; c < 500 && nreq < 2; c++) begin
            @(posedge Clk); #1;
            if (CntRequest) nreq++;
        end
        chk("abort_second_req_seen", nreq, 2);
        Abort = 1'b1;
        @(posedge Clk); #1;
        Abort = 1'b0;
        wait_done(seen);
        chk("abort_remaining_2", Remaining, 2);
        chk("abort_aborted", Aborted, 1);
        chk("abort_counter_102", cnt_val, 102);
        chk("abort_unissued_reqs", exp_q.size(), 2);
        exp_q.delete();
        repeat (3) @(negedge Clk);
        chk("abort_done_once", done_cnt, 1);

        // Abort in IDLE is ignored by the next command.
        @(posedge Clk); #1 Abort = 1'b1;
        @(posedge Clk); #1 Abort = 1'b0;
        run_cmd(1'b1, 1'b0, 0, 1, 1'b0, 1'b0, 1'b0);

        // Steps=0, Load=0: Done two cycles after Start, Start while busy ignored.
        @(posedge Clk); #1;
        Dec = 1'b0; Load = 1'b0; Steps = '0; StopOnZero = 1'b0;
        done_cnt = 0;
        Start = 1'b1;
        @(posedge Clk); #1;
        chk("s0_busy_next", Busy, 1);
        chk("s0_done_not_yet", Done, 0);
        @(posedge Clk); #1;
        chk("s0_done_at_2", Done, 1);
        chk("s0_busy_with_done", Busy, 0);
        Start = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        chk("s0_no_restart", Busy, 0);
        chk("s0_done_once", done_cnt, 1);

        // Start while busy on a longer command.
        preload(40);
        run_cmd(1'b0, 1'b1, 5, 4, 1'b0, 1'b0, 1'b1);
        chk("glitch_counter_9", cnt_val, 9);

        // Reset during WAIT_RDY abandons the command.
        preload(50);
        model_cmd(cnt_val, 1'b0, 1'b0, 0, 3, 1'b0, 1'b0, ev, er, es);
        issue_start(1'b0, 1'b0, 0, 3, 1'b0);
        hit = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge Clk); #1;
            if (DbgState == WAIT_RDY) begin
                hit = 1'b1;
                break;
            end
        end
        chk("rst_reached_wait_rdy", hit, 1);
        #2 Rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        repeat (3) @(posedge Clk);
        #1 Rst_n = 1'b1;
        repeat (6) @(negedge Clk);
        chk("rst_no_done", done_cnt, 0);
        for (int c = 0; c < 50 && !cnt_ready; c++) @(negedge Clk);
        chk("rst_counter_51", cnt_val, 51);
        run_cmd(1'b0, 1'b0, 0, 2, 1'b0, 1'b0, 1'b0);
        chk("rst_then_counter_53", cnt_val, 53);

        // Stalled counter: every operation completes via the acknowledge timeout.
        preload(20);
        stall = 1'b1;
        run_cmd(1'b0, 1'b0, 0, 3, 1'b0, 1'b1, 1'b0);
        chk("stall_counter_20", cnt_val, 20);
        chk("stall_remaining_0", Remaining, 0);
        stall = 1'b0;

        // Randomized commands.
        for (int n = 0; n < 10; n++) begin
            pick = $urandom_range(0, 2);
            if (pick == 0) v0 = $urandom_range(0, 5);
            else if (pick == 1) v0 = 999995 + $urandom_range(0, 4);
            else v0 = $urandom_range(0, 999999);
            preload(v0);
            begin
                bit rd, rl, rs, rg;
                int rlv, rst;
                rd  = 1'($urandom_range(0, 1));
                rl  = ($urandom_range(0, 3) == 0);
                rlv = $urandom_range(0, 6);
                rst = $urandom_range(0, 12);
                rs  = 1'($urandom_range(0, 1));
                rg  = (rst >= 2) && ($urandom_range(0, 1) == 1);
                run_cmd(rd, rl, rlv, rst, rs, 1'b0, rg);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog bounding the whole run.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
